// File: rtl/page_walker_pkg.sv
// Shared definitions for the page-table walker: FSM state encoding,
// PTE field positions and address-geometry helpers.
package page_walker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_FAULT = 2'd3
    } walk_state_e;

    localparam int unsigned PTE_VALID_BIT = 0;
    localparam int unsigned PTE_LEAF_BIT  = 1;
    localparam int unsigned PTE_PPN_HI    = 51;
    localparam int unsigned PTE_PPN_LO    = 12;
    localparam int unsigned PAGE_SHIFT    = 12;
    localparam int unsigned IDX_BITS      = 9;
    localparam int unsigned PPN_BITS      = PTE_PPN_HI - PTE_PPN_LO + 1;

    // Bit position of the VA index field for a given level.
    function automatic int unsigned level_shift(input int unsigned level);
        return PAGE_SHIFT + IDX_BITS * level;
    endfunction

    // Mask covering the page-offset bits of a page whose offset is `shift` bits wide.
    function automatic logic [63:0] offset_mask(input int unsigned shift);
        logic [63:0] m;
        if (shift >= 64) begin
            m = '1;
        end else begin
            m = (64'd1 << shift) - 64'd1;
        end
        return m;
    endfunction

    // Table index selected by the VA at a given level.
    function automatic logic [63:0] va_index(input logic [63:0] va, input int unsigned level);
        logic [63:0] idx;
        idx = (va >> level_shift(level)) & 64'((1 << IDX_BITS) - 1);
        return idx;
    endfunction

endpackage

// File: rtl/page_walker_decode.sv
// pte_decode: combinational PTE interpretation for the walker.
// Produces the valid/leaf flags, the next-level table base and the
// physical address of a leaf mapping (superpage offset taken from the VA).
module pte_decode
    import page_walker_pkg::*;
#(
    parameter int unsigned LW = 2
) (
    input  logic [63:0]   pte,
    input  logic [LW-1:0] level,
    input  logic [63:0]   va,
    output logic          valid,
    output logic          leaf,
    output logic [63:0]   next_base,
    output logic [63:0]   leaf_pa
);

    logic [PPN_BITS-1:0] ppn;
    logic [63:0]         frame;
    logic [63:0]         mask;

    // Field extraction and leaf address composition.
    always_comb begin
        ppn       = pte[PTE_PPN_HI:PTE_PPN_LO];
        frame     = {{(64 - PAGE_SHIFT - PPN_BITS){1'b0}}, ppn, {PAGE_SHIFT{1'b0}}};
        mask      = offset_mask(level_shift(32'(level)));
        valid     = pte[PTE_VALID_BIT];
        leaf      = pte[PTE_LEAF_BIT];
        next_base = frame;
        leaf_pa   = (frame & ~mask) | (va & mask);
    end

endmodule

// File: rtl/page_walker.sv
// page_walker: hardware page-table walker servicing TLB misses.
// Walks LEVELS levels of 512-entry tables, then fills the TLB or faults.
// Optional build macro: WALK_STATS_EN adds stat_walks / stat_faults counters.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int unsigned LEVELS    = 4,
    parameter int unsigned PTE_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shutdown,
    input  logic        miss,
    input  logic [63:0] va,
    input  logic [11:0] pcid,
    input  logic [63:0] root,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        insert,
    output logic [63:0] o_va,
    output logic [63:0] o_pa,
    output logic [11:0] o_pcid,
    output logic        busy,
    output logic        fault
`ifdef WALK_STATS_EN
    ,
    output logic [63:0] stat_walks,
    output logic [63:0] stat_faults
`endif
);

    localparam int unsigned LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    walk_state_e   state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [63:0]   base_q, base_d;
    logic [63:0]   va_q, va_d;
    logic [11:0]   pcid_q, pcid_d;
    logic [63:0]   pa_q, pa_d;

    logic          pte_valid;
    logic          pte_leaf;
    logic [63:0]   pte_next_base;
    logic [63:0]   pte_leaf_pa;
    logic [63:0]   pte_addr;

    pte_decode #(
        .LW (LW)
    ) u_decode (
        .pte       (mem_rdata),
        .level     (level_q),
        .va        (va_q),
        .valid     (pte_valid),
        .leaf      (pte_leaf),
        .next_base (pte_next_base),
        .leaf_pa   (pte_leaf_pa)
    );

    // Address of the PTE for the current level; wraps modulo 2^64.
    always_comb begin
        pte_addr = base_q + va_index(va_q, 32'(level_q)) * 64'(PTE_BYTES);
    end

    // Next-state and walk-context update; shutdown overrides everything,
    // including a same-cycle miss or mem_ack.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        base_d  = base_q;
        va_d    = va_q;
        pcid_d  = pcid_q;
        pa_d    = pa_q;
        if (shutdown) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        va_d    = va;
                        pcid_d  = pcid;
                        base_d  = root;
                        level_d = LW'(LEVELS - 1);
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        if (!pte_valid) begin
                            state_d = ST_FAULT;
                        end else if (pte_leaf) begin
                            pa_d    = pte_leaf_pa;
                            state_d = ST_FILL;
                        end else if (level_q != '0) begin
                            base_d  = pte_next_base;
                            level_d = level_q - 1'b1;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end
                end
                ST_FILL, ST_FAULT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        mem_req  = (state_q == ST_REQ) && !shutdown;
        mem_addr = (state_q == ST_REQ) ? pte_addr : '0;
        insert   = (state_q == ST_FILL) && !shutdown;
        fault    = (state_q == ST_FAULT) && !shutdown;
        o_va     = va_q;
        o_pa     = pa_q;
        o_pcid   = pcid_q;
    end

    // State and walk-context registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            base_q  <= '0;
            va_q    <= '0;
            pcid_q  <= '0;
            pa_q    <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            base_q  <= base_d;
            va_q    <= va_d;
            pcid_q  <= pcid_d;
            pa_q    <= pa_d;
        end
    end

`ifdef WALK_STATS_EN
    logic [63:0] walks_q, walks_d;
    logic [63:0] faults_q, faults_d;

    // FILL and FAULT are only entered from REQ, so state_d marks each entry once.
    always_comb begin
        walks_d  = walks_q + ((state_d == ST_FILL) ? 64'd1 : 64'd0);
        faults_d = faults_q + ((state_d == ST_FAULT) ? 64'd1 : 64'd0);
    end

    // Statistics counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walks_q  <= '0;
            faults_q <= '0;
        end else begin
            walks_q  <= walks_d;
            faults_q <= faults_d;
        end
    end

    always_comb begin
        stat_walks  = walks_q;
        stat_faults = faults_q;
    end
`endif

endmodule

// File: doc/page_walker.md
PAGE_WALKER -- requirements
Module: page_walker

Interface
REQ-001 SHALL provide parameter LEVELS, default 4, number of translation levels walked (9 VA index bits per level, 4 KiB base page).
REQ-002 SHALL provide parameter PTE_BYTES, default 8, byte stride between page-table entries.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port shutdown  input  1  synchronous abort of any walk in progress.
REQ-006 SHALL have port miss  input  1  TLB miss strobe; starts a walk when idle.
REQ-007 SHALL have port va  input  64  faulting virtual address, sampled with miss.
REQ-008 SHALL have port pcid  input  12  address-space id, sampled with miss.
REQ-009 SHALL have port root  input  64  page-table root base address, sampled with miss.
REQ-010 SHALL have ports mem_req  output  1, mem_addr  output  64, mem_ack  input  1, mem_rdata  input  64: PTE read handshake.
REQ-011 SHALL have ports insert  output  1, o_va  output  64, o_pa  output  64, o_pcid  output  12: TLB fill, one-cycle pulse.
REQ-012 SHALL have ports busy  output  1, fault  output  1 (one-cycle pulse on failed walk).

Function
REQ-013 SHALL implement states IDLE, REQ, FILL, FAULT; busy=1 in every state except IDLE.
REQ-014 IDLE: miss=1 SHALL latch va, pcid, root, set level=LEVELS-1, base=root, go to REQ next cycle; miss while busy SHALL be ignored.
REQ-015 REQ: mem_req SHALL be held 1 with mem_addr = base + va[12+9*level +: 9]*PTE_BYTES, stable until mem_ack=1 is sampled.
REQ-016 On mem_ack, PTE=mem_rdata; valid=bit0, leaf=bit1, ppn=bits[51:12].
REQ-017 PTE invalid -> FAULT.
REQ-018 PTE valid, leaf -> FILL with o_pa = {ppn, 12'b0} with the low 12+9*level bits replaced by va bits (superpage at level>0).
REQ-019 PTE valid, non-leaf, level>0 -> base={12'b0, ppn, 12'b0}, level-1, remain in REQ; non-leaf at level 0 -> FAULT.
REQ-020 FILL: insert=1 for exactly one cycle with o_va/o_pcid = latched values, then IDLE.
REQ-021 FAULT: fault=1 for exactly one cycle, insert stays 0, then IDLE.
REQ-022 Minimum latency miss->insert SHALL be LEVELS+1 cycles with zero-wait mem_ack.
REQ-023 shutdown=1 in any state SHALL force IDLE next cycle, drop mem_req, suppress insert/fault; a mem_ack in that cycle is discarded.
REQ-024 shutdown and miss in the same cycle: shutdown wins, walk not started.
REQ-025 Address arithmetic SHALL be 64-bit modulo 2^64; overflow wraps silently.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE and drive mem_req, insert, fault, busy=0; mem_addr, o_va, o_pa, o_pcid=0.
REQ-027 rst asserted mid-walk SHALL abandon the walk; no insert or fault follows deassertion.

Configuration
REQ-028 Macro WALK_STATS_EN defined: SHALL add outputs stat_walks, stat_faults (64-bit each), incremented on every entry to FILL and FAULT respectively, cleared by rst only, wrapping at 2^64-1.
REQ-029 Macro WALK_STATS_EN undefined: counters and ports SHALL be absent; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the state enum, PTE bit positions (VALID=0, LEAF=1, PPN 51:12), PAGE_SHIFT=12, IDX_BITS=9.
REQ-031 One sub-module, pte_decode (combinational: PTE, level, va -> valid, leaf, next base, leaf pa), SHALL be instantiated.

Verification
REQ-032 root=0x1000, va=0x0000_0040_1234_5678, 4-level valid chain, leaf at level 0 ppn=0xABCDE, zero-wait ack -> mem_addr sequence computed per REQ-015, insert at cycle 5 with o_pa=0xABCDE678.
REQ-033 Level-1 PTE leaf ppn=0x200 (2 MiB page), va low 21 bits=0x15678 -> o_pa=0x215678 after 3 reads.
REQ-034 Level-2 PTE mem_rdata=0 -> fault pulse one cycle, insert never asserted, busy low next cycle.
REQ-035 mem_ack held low 7 cycles in level 3 -> mem_req and mem_addr stable all 7 cycles; second miss during walk ignored.
REQ-036 shutdown pulsed while waiting on level-1 ack, ack arriving same cycle -> IDLE, no insert/fault; rst mid-walk -> all outputs 0 asynchronously.
REQ-037 With WALK_STATS_EN: two successful walks, one fault -> stat_walks=2, stat_faults=1.
